uart_rx_cmd_ctrl: RTL
=====================

// Module: uart_rx_cmd_ctrl
// PURPOSE
//  Sequences the byte stream of the UART receiver into framed command packets for the design top.
//  Hunts for a sync byte, then takes a length byte, payload bytes and an XOR checksum.
//  Writes the payload into an external buffer and then presents a validated command to the consumer.
//  Enforces an inter-byte timeout and counts errors.
// PARAMETERS
//  SYNC_BYTE    8'hA5    packet start marker
//  MAX_LEN      16       largest legal payload length in bytes (1..255)
//  TIMEOUT_CYC  208332   idle clocks allowed between bytes inside a packet (2 byte times, 9600 baud, 100 MHz)
//  TW           18       timeout counter width; must satisfy 2**TW > TIMEOUT_CYC
// PORTS
//  clk           in   1   system clock, 100 MHz
//  reset         in   1   asynchronous reset, active-high
//  rx_data       in   8   byte from UART receiver
//  rx_valid      in   1   one-cycle strobe: rx_data holds a new byte
//  rx_frame_err  in   1   one-cycle strobe: receiver saw a bad stop bit
//  wr_en         out  1   payload buffer write strobe
//  wr_addr       out  8   payload byte index, 0-based
//  wr_data       out  8   payload byte
//  cmd_valid     out  1   validated command available; held until accepted
//  cmd_len       out  8   payload length of the presented command
//  cmd_ready     in   1   consumer accepts the command when cmd_valid=1
//  err_chk       out  1   one-cycle pulse: checksum mismatch
//  err_len       out  1   one-cycle pulse: length 0 or greater than MAX_LEN
//  err_timeout   out  1   one-cycle pulse: inter-byte timeout
//  err_frame     out  1   one-cycle pulse: frame error inside a packet
//  err_cnt       out  8   total error count, saturates at 8'hFF
//  busy          out  1   1 in any state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; checksum register, byte index and timer cleared. Async assert, sync release.
//  FSM states and transitions:
//   IDLE: byte == SYNC_BYTE -> LEN. Any other byte and any frame error are ignored; nothing is counted.
//   LEN: byte in 1..MAX_LEN -> DATA. Load chk=byte, idx=0, cmd_len=byte.
//        Any other value -> IDLE with err_len.
//   DATA: each byte gives wr_en=1, wr_addr=idx, wr_data=byte one cycle after rx_valid.
//         Then chk^=byte and idx++. When idx reaches cmd_len-1 the state moves to CHK.
//   CHK: byte == chk -> DONE with cmd_valid=1 one cycle after rx_valid.
//        Otherwise -> IDLE with err_chk. No wr_en is issued in this state.
//   DONE: cmd_valid and cmd_len are held stable. cmd_valid & cmd_ready -> IDLE; cmd_valid drops the next cycle.
//         Bytes arriving in DONE are dropped and do not count as errors.
//  Timeout: applies in LEN, DATA and CHK only.
//   The timer clears on every rx_valid and on entry to the state.
//   The timer counts up on every other cycle.
//   At count == TIMEOUT_CYC-1 the FSM goes to IDLE and pulses err_timeout.
//  Frame error: in LEN, DATA or CHK the FSM goes to IDLE and pulses err_frame.
//   The byte in the same cycle is discarded.
//  Simultaneous events:
//   rx_valid in the same cycle as timer expiry: the byte wins and the timer clears.
//   rx_frame_err together with rx_valid: the frame error wins.
//  Error counting: each err_* pulse increments err_cnt by 1, saturating at 8'hFF.
//   At most one err_* pulse fires per cycle.
//  Aborted packet: payload already written stays in the buffer. cmd_valid is never raised for it.
//   The next packet overwrites the buffer from addr 0.
//  Latency: checksum byte strobe to cmd_valid = 1 cycle. Payload byte strobe to wr_en = 1 cycle.
//  Widths: chk is 8 bits and idx is 8 bits; both wrap naturally. MAX_LEN<=255 so idx never wraps in use.
//  Reset mid-packet: immediate return to IDLE. No error pulse; err_cnt clears.
// TESTING
//  1. Bytes A5 03 11 22 33 03 -> writes (0,11)(1,22)(2,33); then cmd_valid=1, cmd_len=3.
//     Hold until cmd_ready=1, then cmd_valid=0 next cycle.
//  2. Same packet with checksum 04 -> err_chk pulse, err_cnt=1, no cmd_valid, busy=0.
//  3. Bytes A5 00 and A5 11 (MAX_LEN=16) -> two err_len pulses, err_cnt=2, no wr_en.
//  4. Bytes A5 02 11, then no byte for TIMEOUT_CYC clocks -> err_timeout exactly once, FSM in IDLE.
//     A following full good packet is accepted.
//  5. Leading noise bytes 00 FF 5A, then a valid packet -> noise ignored, err_cnt unchanged, packet accepted.
//     rx_frame_err during the payload -> err_frame pulse and abort.
//  6. reset=1 mid-DATA -> all outputs 0 asynchronously. After release, A5 01 7E 7F -> cmd_valid, cmd_len=1.

Source files
------------

// File: rtl/uart_rx_cmd_ctrl.sv
// Frames the UART receiver byte stream into command packets: SYNC, LEN, payload, XOR checksum.
// Payload goes to an external buffer; a validated command is held until the consumer accepts it.
module uart_rx_cmd_ctrl #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 208332,
    parameter int         TW          = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_frame_err,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       cmd_valid,
    output logic [7:0] cmd_len,
    input  logic       cmd_ready,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_timeout,
    output logic       err_frame,
    output logic [7:0] err_cnt,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, DONE} state_t;

    localparam logic [7:0]    MAX_LEN_B = MAX_LEN[7:0];
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    state_t        state;
    logic [7:0]    chk;
    logic [7:0]    idx;
    logic [TW-1:0] timer;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            chk         <= '0;
            idx         <= '0;
            timer       <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            cmd_valid   <= 1'b0;
            cmd_len     <= '0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_frame   <= 1'b0;
            err_cnt     <= '0;
        end else begin
            wr_en       <= 1'b0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_frame   <= 1'b0;

            case (state)
                IDLE: begin
                    timer <= '0;
                    // A byte flagged with a frame error is never taken as a sync byte.
                    if (rx_valid && !rx_frame_err && rx_data == SYNC_BYTE)
                        state <= LEN;
                end

                LEN, DATA, CHK: begin
                    // Priority: frame error, then a byte, then timer expiry.
                    if (rx_frame_err) begin
                        state     <= IDLE;
                        err_frame <= 1'b1;
                        err_cnt   <= sat_inc(err_cnt);
                    end else if (rx_valid) begin
                        timer <= '0;
                        case (state)
                            LEN: begin
                                if (rx_data != 8'd0 && rx_data <= MAX_LEN_B) begin
                                    state   <= DATA;
                                    chk     <= rx_data;
                                    idx     <= '0;
                                    cmd_len <= rx_data;
                                end else begin
                                    state   <= IDLE;
                                    err_len <= 1'b1;
                                    err_cnt <= sat_inc(err_cnt);
                                end
                            end
                            DATA: begin
                                wr_en   <= 1'b1;
                                wr_addr <= idx;
                                wr_data <= rx_data;
                                chk     <= chk ^ rx_data;
                                idx     <= idx + 8'd1;
                                if (idx == cmd_len - 8'd1)
                                    state <= CHK;
                            end
                            CHK: begin
                                if (rx_data == chk) begin
                                    state     <= DONE;
                                    cmd_valid <= 1'b1;
                                end else begin
                                    state   <= IDLE;
                                    err_chk <= 1'b1;
                                    err_cnt <= sat_inc(err_cnt);
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end else if (timer == TMO_LAST) begin
                        state       <= IDLE;
                        err_timeout <= 1'b1;
                        err_cnt     <= sat_inc(err_cnt);
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                DONE: begin
                    // Incoming bytes and frame errors are dropped while a command is pending.
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
